// File: rtl/ob_mk_table_qty_sum.sv
// Market-order table quantity accumulator: snapshots valid slot quantities
// on a query and sums LANES slots per cycle with a saturating total.
package ob_pkg;
    typedef logic [15:0] quantity_t;
    typedef logic [18:0] accum_quantity_t;

    typedef struct packed {
        logic [31:0] order_id;
        quantity_t   quantity;
    } table_t;
endpackage

module ob_mk_table_qty_sum #(
    parameter int N     = 16,
    parameter int LANES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_vld,
    input  ob_pkg::table_t [N-1:0]     tbl_r,
    input  logic [N-1:0]               tbl_vld_r,
    output logic                       busy_w,
    output logic                       busy_r,
    output ob_pkg::accum_quantity_t    rsp_quantity_w,
    output logic                       rsp_vld_r,
    output ob_pkg::accum_quantity_t    rsp_quantity_r,
    output logic                       rsp_sat_r
);
    import ob_pkg::*;

    localparam int STEPS = N / LANES;
    localparam int PW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int ACC_W = $bits(accum_quantity_t);
    // Wide enough that acc + one lane group can never wrap
    localparam int SUM_W = ACC_W + $clog2(LANES) + 1;

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t                         state_q, state_d;
    quantity_t [STEPS-1:0][LANES-1:0] snap_q, snap_d;
    accum_quantity_t                acc_q, acc_d;
    logic [PW-1:0]                  ptr_q, ptr_d;
    logic                           sat_q, sat_d;
    logic                           rsp_vld_q, rsp_vld_d;
    accum_quantity_t                rsp_quantity_q, rsp_quantity_d;
    logic                           rsp_sat_q, rsp_sat_d;

    logic [SUM_W-1:0]               lane_sum;
    logic [SUM_W-1:0]               sum_full;
    logic                           ovf;
    accum_quantity_t                acc_sum;
    logic                           unused_tbl;

    assign unused_tbl = ^tbl_r;

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + SUM_W'(snap_q[ptr_q][l]);
        end
        sum_full = SUM_W'(acc_q) + lane_sum;
        ovf      = |sum_full[SUM_W-1:ACC_W];
        acc_sum  = ovf ? '1 : sum_full[ACC_W-1:0];
    end

    always_comb begin
        state_d        = state_q;
        snap_d         = snap_q;
        acc_d          = acc_q;
        ptr_d          = ptr_q;
        sat_d          = sat_q;
        rsp_vld_d      = rsp_vld_q;
        rsp_quantity_d = rsp_quantity_q;
        rsp_sat_d      = rsp_sat_q;
        busy_w         = 1'b0;

        if (cmd_vld) begin
            for (int s = 0; s < STEPS; s++) begin
                for (int l = 0; l < LANES; l++) begin
                    snap_d[s][l] = tbl_vld_r[s*LANES+l] ?
                                   tbl_r[s*LANES+l].quantity : '0;
                end
            end
            acc_d     = '0;
            ptr_d     = '0;
            sat_d     = 1'b0;
            rsp_vld_d = 1'b0;
            state_d   = COUNT;
            busy_w    = 1'b1;
        end else if (state_q == COUNT) begin
            acc_d = acc_sum;
            sat_d = sat_q | ovf;
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == PW'(STEPS-1)) begin
                ptr_d          = '0;
                state_d        = IDLE;
                rsp_quantity_d = acc_sum;
                rsp_sat_d      = sat_q | ovf;
                rsp_vld_d      = 1'b1;
            end else begin
                busy_w = 1'b1;
            end
        end
    end

    assign rsp_quantity_w = acc_d;
    assign busy_r         = (state_q == COUNT);
    assign rsp_vld_r      = rsp_vld_q;
    assign rsp_quantity_r = rsp_quantity_q;
    assign rsp_sat_r      = rsp_sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            ptr_q          <= '0;
            sat_q          <= 1'b0;
            rsp_vld_q      <= 1'b0;
            rsp_quantity_q <= '0;
            rsp_sat_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            ptr_q          <= ptr_d;
            sat_q          <= sat_d;
            rsp_vld_q      <= rsp_vld_d;
            rsp_quantity_q <= rsp_quantity_d;
            rsp_sat_q      <= rsp_sat_d;
        end
    end

    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

endmodule

// File: tb/tb_ob_mk_table_qty_sum.sv
// Directed bench for ob_mk_table_qty_sum with a queue-based scoreboard
// of expected totals checked against response timing.
module tb_ob_mk_table_qty_sum;
    import ob_pkg::*;

    localparam int N     = 16;
    localparam int LANES = 4;
    localparam int STEPS = N / LANES;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_vld;
    table_t [N-1:0]     tbl;
    logic [N-1:0]       vld;
    logic               busy_w;
    logic               busy_r;
    accum_quantity_t    rsp_quantity_w;
    logic               rsp_vld_r;
    accum_quantity_t    rsp_quantity_r;
    logic               rsp_sat_r;

    typedef struct packed {
        accum_quantity_t q;
        logic            sat;
    } exp_t;

    exp_t           sb[$];
    exp_t           e;
    table_t [N-1:0] alt_t;
    int             checks   = 0;
    int             failures = 0;

    ob_mk_table_qty_sum #(.N(N), .LANES(LANES)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_vld        (cmd_vld),
        .tbl_r          (tbl),
        .tbl_vld_r      (vld),
        .busy_w         (busy_w),
        .busy_r         (busy_r),
        .rsp_quantity_w (rsp_quantity_w),
        .rsp_vld_r      (rsp_vld_r),
        .rsp_quantity_r (rsp_quantity_r),
        .rsp_sat_r      (rsp_sat_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t   r;
        longint s;
        longint mx;
        s  = 0;
        mx = (64'd1 << $bits(accum_quantity_t)) - 1;
        for (int i = 0; i < N; i++) begin
            if (vld[i]) s += longint'(tbl[i].quantity);
        end
        r.sat = (s > mx);
        r.q   = r.sat ? '1 : accum_quantity_t'(s);
        return r;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int mode, input int val);
        for (int i = 0; i < N; i++) begin
            tbl[i].order_id = $urandom;
            tbl[i].quantity = (mode == 0) ? quantity_t'(i + 1)
                                          : quantity_t'(val);
        end
    endtask

    task automatic pop_rsp(input string tag);
        chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_rsp_vld_r"}, rsp_vld_r, 1);
            chk({tag, "_rsp_quantity_r"}, rsp_quantity_r, e.q);
            chk({tag, "_rsp_sat_r"}, rsp_sat_r, e.sat);
        end
    endtask

    // Full query: cmd in cycle 0, busy window, response in cycle STEPS+1.
    // Table is swapped to alt_t/alt_v in cycle mod_cyc (0 = never).
    task automatic query(input string tag, input int mod_cyc,
                         input logic [N-1:0] alt_v);
        cmd_vld = 1'b1;
        sb.push_back(model());
        @(negedge clk);
        chk({tag, "_c0_busy_w"}, busy_w, 1);
        chk({tag, "_c0_busy_r"}, busy_r, 0);
        next();
        cmd_vld = 1'b0;
        for (int k = 1; k <= STEPS; k++) begin
            if (k == mod_cyc) begin
                tbl = alt_t;
                vld = alt_v;
            end
            @(negedge clk);
            chk({tag, "_busy_r"}, busy_r, 1);
            chk({tag, "_rsp_vld_low"}, rsp_vld_r, 0);
            if (k < STEPS) begin
                chk({tag, "_busy_w_hi"}, busy_w, 1);
            end else begin
                chk({tag, "_busy_w_fall"}, busy_w, 0);
                if (sb.size() > 0)
                    chk({tag, "_rsp_quantity_w"}, rsp_quantity_w, sb[0].q);
            end
            next();
        end
        @(negedge clk);
        chk({tag, "_idle_busy_r"}, busy_r, 0);
        pop_rsp(tag);
        next();
    endtask

    initial begin
        rst     = 1'b1;
        cmd_vld = 1'b0;
        vld     = '0;
        fill(0, 0);
        alt_t   = tbl;
        next();
        next();
        @(negedge clk);
        chk("reset_busy_r", busy_r, 0);
        chk("reset_busy_w", busy_w, 0);
        chk("reset_rsp_vld_r", rsp_vld_r, 0);
        chk("reset_rsp_quantity_r", rsp_quantity_r, 0);
        chk("reset_rsp_sat_r", rsp_sat_r, 0);
        next();
        rst = 1'b0;
        next();

        // Basic: quantities 1..16 all valid -> 136
        fill(0, 0);
        vld = '1;
        query("basic", 0, '0);
        chk("basic_total_literal", rsp_quantity_r, 136);

        // Valid masking
        fill(1, 100);
        vld = 16'h00F0;
        query("mask", 0, '0);
        chk("mask_total_literal", rsp_quantity_r, 400);

        // Empty table with stale quantities
        fill(1, 500);
        vld = '0;
        query("empty", 0, '0);

        // Snapshot isolation: table rewritten in cycle 2
        fill(1, 10);
        vld = 16'h000F;
        for (int i = 0; i < N; i++) begin
            alt_t[i].order_id = $urandom;
            alt_t[i].quantity = 16'd999;
        end
        query("snap", 2, '1);
        chk("snap_total_literal", rsp_quantity_r, 40);

        // Restart in cycle 3
        fill(0, 0);
        vld     = '1;
        cmd_vld = 1'b1;
        sb.push_back(model());
        @(negedge clk);
        chk("rst0_busy_w", busy_w, 1);
        next();
        cmd_vld = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("rs_busy_w_hi", busy_w, 1);
            chk("rs_rsp_vld_low", rsp_vld_r, 0);
            next();
        end
        fill(1, 1);
        cmd_vld = 1'b1;
        void'(sb.pop_back());
        sb.push_back(model());
        @(negedge clk);
        chk("rs3_busy_w", busy_w, 1);
        chk("rs3_rsp_vld_low", rsp_vld_r, 0);
        next();
        cmd_vld = 1'b0;
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            chk("rs_busy_r", busy_r, 1);
            chk("rs_rsp_vld_low", rsp_vld_r, 0);
            if (k < 7) begin
                chk("rs_busy_w_hi", busy_w, 1);
            end else begin
                chk("rs_busy_w_fall", busy_w, 0);
                chk("rs_rsp_quantity_w", rsp_quantity_w, 16);
            end
            next();
        end
        @(negedge clk);
        pop_rsp("restart");
        chk("restart_total_literal", rsp_quantity_r, 16);
        next();

        // Saturation, then a normal query clears the flag
        fill(1, 16'hFFFF);
        vld = '1;
        query("sat", 0, '0);
        chk("sat_all_ones", rsp_quantity_r, 19'h7FFFF);
        chk("sat_flag", rsp_sat_r, 1);
        fill(0, 0);
        vld = 16'h0003;
        query("unsat", 0, '0);
        chk("unsat_flag", rsp_sat_r, 0);

        // Reset mid-count
        fill(0, 0);
        vld     = '1;
        cmd_vld = 1'b1;
        sb.push_back(model());
        next();
        cmd_vld = 1'b0;
        next();
        rst = 1'b1;
        sb.delete();
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy_r", busy_r, 0);
        chk("midrst_rsp_vld_r", rsp_vld_r, 0);
        chk("midrst_rsp_quantity_r", rsp_quantity_r, 0);
        chk("midrst_rsp_sat_r", rsp_sat_r, 0);
        next();
        fill(1, 7);
        vld = 16'hFF00;
        query("post_rst", 0, '0);
        chk("post_rst_literal", rsp_quantity_r, 56);

        // rst and cmd_vld together: cmd dropped
        rst     = 1'b1;
        cmd_vld = 1'b1;
        next();
        rst     = 1'b0;
        cmd_vld = 1'b0;
        @(negedge clk);
        chk("rst_cmd_busy_r", busy_r, 0);
        chk("rst_cmd_rsp_vld_r", rsp_vld_r, 0);
        next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
